// File: rtl/uart_frame_writer.sv
// uart_frame_writer
//
// Takes bytes from the UART receiver, waits for a sync byte, packs every
// BYTES_PER_PIXEL bytes into one pixel word (first byte in the MSBs) and
// writes the pixels to consecutive frame-buffer addresses. A small FIFO
// absorbs frame-buffer stalls. If the FIFO is full, the pixel is dropped.
// The address counter still advances so later pixels land where they belong.
//
// Ports
//   clock       system clock, rising edge
//   reset_n     synchronous reset, active-low
//   rx_data     received byte, valid when rx_done=1
//   rx_done     one-cycle byte strobe
//   wr_addr     frame-buffer write address (FIFO head)
//   wr_data     packed pixel (FIFO head)
//   wr_valid    write request, FIFO not empty
//   wr_ready    frame buffer accepts when wr_valid & wr_ready
//   frame_done  one-cycle pulse once the frame has fully left the block
//   overflow    sticky, a pixel was dropped on a full FIFO
//   busy        high while collecting or draining a frame
//
// State       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | hunting for SYNC_BYTE, other bytes ignored
// ST_COLLECT  | packing bytes into pixels and pushing them to the FIFO
// ST_DRAIN    | last pixel pushed (or dropped), waiting for the FIFO to empty

module uart_frame_writer #(
    parameter int               DBITS           = 8,
    parameter int               BYTES_PER_PIXEL = 3,
    parameter int               PIXEL_COUNT     = 307200,
    parameter int               ADDR_BITS       = 19,
    parameter logic [DBITS-1:0] SYNC_BYTE       = 8'hA5,
    parameter int               FIFO_DEPTH      = 4
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [DBITS-1:0]                   rx_data,
    input  logic                               rx_done,
    output logic [ADDR_BITS-1:0]               wr_addr,
    output logic [DBITS*BYTES_PER_PIXEL-1:0]   wr_data,
    output logic                               wr_valid,
    input  logic                               wr_ready,
    output logic                               frame_done,
    output logic                               overflow,
    output logic                               busy
);

    localparam int PIX_W  = DBITS * BYTES_PER_PIXEL;
    localparam int BCNT_W = $clog2(BYTES_PER_PIXEL + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = ADDR_BITS + PIX_W;

    localparam logic [BCNT_W-1:0]    LAST_BYTE = BCNT_W'(BYTES_PER_PIXEL - 1);
    localparam logic [BCNT_W-1:0]    BCNT_ONE  = BCNT_W'(1);
    localparam logic [ADDR_BITS-1:0] LAST_PIX  = ADDR_BITS'(PIXEL_COUNT - 1);
    localparam logic [ADDR_BITS-1:0] PIX_ONE   = ADDR_BITS'(1);
    localparam logic [PTR_W:0]       DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]       PTR_ONE   = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BCNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [ADDR_BITS-1:0] pix_cnt_q,  pix_cnt_d;
    logic [PIX_W-1:0]     pack_q,     pack_d;
    logic                 overflow_q;
    logic                 frame_done_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];

    logic                 sync_seen;
    logic                 collect_en;
    logic                 last_byte;
    logic                 last_pix;
    logic                 push;
    logic                 push_ok;
    logic                 drop;
    logic                 pop;
    logic [PTR_W:0]       fifo_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 drain_done;
    logic                 frame_end;
    logic [PIX_W-1:0]     pack_shift;
    logic [ENT_W-1:0]     head;

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign pop        = !fifo_empty && wr_ready;

    // A full FIFO still takes a pixel when the head leaves on the same edge.
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && !push_ok;

    // Nothing is pushed while draining, so "one entry left and it is being
    // popped" means the FIFO is empty after this edge.
    assign drain_done = fifo_empty || ((fifo_cnt == PTR_ONE) && pop);

    assign sync_seen  = rx_done && (rx_data == SYNC_BYTE);
    assign last_byte  = (byte_cnt_q == LAST_BYTE);
    assign last_pix   = (pix_cnt_q == LAST_PIX);

    // Shifting by the full byte width also covers BYTES_PER_PIXEL == 1.
    assign pack_shift = (pack_q << DBITS) | PIX_W'(rx_data);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_seen) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_done && last_byte && last_pix) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        collect_en = 1'b0;
        frame_end  = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                busy       = 1'b1;
                collect_en = 1'b1;
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                frame_end = drain_done;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte packing and pixel counting
    // ------------------------------------------------------------------
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        pack_d     = pack_q;
        push       = 1'b0;

        if ((state_q == ST_IDLE) && sync_seen) begin
            byte_cnt_d = '0;
            pix_cnt_d  = '0;
        end

        if (collect_en && rx_done) begin
            pack_d = pack_shift;
            if (last_byte) begin
                push       = 1'b1;
                byte_cnt_d = '0;
                // The last pixel leaves pix_cnt alone; the next sync clears it.
                if (!last_pix) begin
                    pix_cnt_d = pix_cnt_q + PIX_ONE;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + BCNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byte_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            pack_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            pack_q       <= pack_d;
            overflow_q   <= overflow_q | drop;
            frame_done_q <= frame_end;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {pix_cnt_q, pack_shift};
        end
    end

    // ------------------------------------------------------------------
    // Write port: head of the FIFO, forced to zero while empty
    // ------------------------------------------------------------------
    assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign wr_valid   = !fifo_empty;
    assign wr_addr    = wr_valid ? head[ENT_W-1:PIX_W] : '0;
    assign wr_data    = wr_valid ? head[PIX_W-1:0]     : '0;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_frame_writer.sv
module tb_uart_frame_writer;

    typedef struct packed {
        logic [2:0]  a;
        logic [23:0] d;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        wr_ready;

    logic [2:0]  wa0, wa1;
    logic [23:0] wd0, wd1;
    logic        wv0, wv1, fd0, fd1, ov0, ov1, bz0, bz1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;
    bit rnd_rdy = 0;

    always #5 clock = ~clock;

    // Instance 0: FIFO of 4; instance 1: FIFO of 2. Same stimulus for both.
    uart_frame_writer #(.DBITS(8), .BYTES_PER_PIXEL(3), .PIXEL_COUNT(4),
                        .ADDR_BITS(3), .SYNC_BYTE(8'hA5), .FIFO_DEPTH(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
        .wr_addr(wa0), .wr_data(wd0), .wr_valid(wv0), .wr_ready(wr_ready),
        .frame_done(fd0), .overflow(ov0), .busy(bz0));

    uart_frame_writer #(.DBITS(8), .BYTES_PER_PIXEL(3), .PIXEL_COUNT(4),
                        .ADDR_BITS(3), .SYNC_BYTE(8'hA5), .FIFO_DEPTH(2)) dut1 (
        .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
        .wr_addr(wa1), .wr_data(wd1), .wr_valid(wv1), .wr_ready(wr_ready),
        .frame_done(fd1), .overflow(ov1), .busy(bz1));

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for sync, 1 receiving pixels, 2 waiting for writes to finish
    int         mode [2];
    int         nb   [2];
    int         pix  [2];
    logic [7:0] cur  [2][3];
    ent_t       fq   [2][4];
    int         fcnt [2];
    bit         movf [2];
    bit         mfd  [2];
    bit         m_pop, m_push, m_fd;
    ent_t       m_e;
    int         m_depth;

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            m_depth = (k == 0) ? 4 : 2;
            if (!reset_n) begin
                mode[k] = 0; nb[k] = 0; pix[k] = 0; fcnt[k] = 0;
                movf[k] = 0; mfd[k] = 0;
            end else begin
                m_pop  = (fcnt[k] > 0) && wr_ready;
                m_push = 0;
                m_fd   = 0;
                if (mode[k] == 2 && (fcnt[k] == 0 || (fcnt[k] == 1 && m_pop))) begin
                    mode[k] = 0;
                    m_fd    = 1;
                end else if (mode[k] == 1 && rx_done) begin
                    cur[k][nb[k]] = rx_data;
                    nb[k]++;
                    if (nb[k] == 3) begin
                        m_e.a  = 3'(pix[k]);
                        m_e.d  = {cur[k][0], cur[k][1], cur[k][2]};
                        m_push = 1;
                        nb[k]  = 0;
                        if (pix[k] == 3) mode[k] = 2;
                        else pix[k]++;
                    end
                end else if (mode[k] == 0 && rx_done && rx_data == 8'hA5) begin
                    mode[k] = 1; nb[k] = 0; pix[k] = 0;
                end
                if (m_pop) begin
                    for (int i = 0; i < 3; i++) fq[k][i] = fq[k][i+1];
                    fcnt[k]--;
                end
                if (m_push) begin
                    if (fcnt[k] < m_depth) begin
                        fq[k][fcnt[k]] = m_e;
                        fcnt[k]++;
                    end else begin
                        movf[k] = 1;
                    end
                end
                mfd[k] = m_fd;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input logic wv, input logic [2:0] wa,
                            input logic [23:0] wd, input logic fd, input logic ov,
                            input logic bz);
        chk($sformatf("i%0d wr_valid", k), 32'(wv), 32'(fcnt[k] > 0));
        if (fcnt[k] > 0) begin
            chk($sformatf("i%0d wr_addr", k), 32'(wa), 32'(fq[k][0].a));
            chk($sformatf("i%0d wr_data", k), 32'(wd), 32'(fq[k][0].d));
        end
        chk($sformatf("i%0d frame_done", k), 32'(fd), 32'(mfd[k]));
        chk($sformatf("i%0d overflow", k), 32'(ov), 32'(movf[k]));
        chk($sformatf("i%0d busy", k), 32'(bz), 32'(mode[k] != 0));
    endtask

    ent_t log0[$], log1[$];
    int   fdc[2];

    always @(negedge clock) begin
        if (chk_en) begin
            cmp_inst(0, wv0, wa0, wd0, fd0, ov0, bz0);
            cmp_inst(1, wv1, wa1, wd1, fd1, ov1, bz1);
            if (wv0 && wr_ready) log0.push_back(ent_t'({wa0, wd0}));
            if (wv1 && wr_ready) log1.push_back(ent_t'({wa1, wd1}));
            if (fd0) fdc[0]++;
            if (fd1) fdc[1]++;
        end
    end

    always @(posedge clock) begin
        if (rnd_rdy) begin
            #1;
            wr_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendb(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_pix(input logic [23:0] p, input int maxgap);
        sendb(p[23:16], $urandom_range(0, maxgap));
        sendb(p[15:8],  $urandom_range(0, maxgap));
        sendb(p[7:0],   $urandom_range(0, maxgap));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bz0 || bz1 || wv0 || wv1) && n < 300) begin
            tick();
            n++;
        end
        tick();
        chk("idle_reached", 32'(bz0 | bz1 | wv0 | wv1), 32'd0);
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        fdc[0] = 0;
        fdc[1] = 0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int k, input int i,
                           input logic [2:0] a, input logic [23:0] d);
        ent_t e;
        if (k == 0) e = (i < log0.size()) ? log0[i] : '1;
        else        e = (i < log1.size()) ? log1[i] : '1;
        chk($sformatf("%s i%0d addr[%0d]", nm, k, i), 32'(e.a), 32'(a));
        chk($sformatf("%s i%0d data[%0d]", nm, k, i), 32'(e.d), 32'(d));
    endtask

    logic [23:0] t1_px [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    logic [23:0] t3_px [4] = '{24'hC0FFEE, 24'h123456, 24'h789ABC, 24'hDEF012};

    initial begin
        logic [7:0]  b;
        logic [23:0] p;

        reset_n  = 1'b0;
        rx_done  = 1'b0;
        rx_data  = 8'h00;
        wr_ready = 1'b1;
        @(posedge clock);
        chk_en = 1;
        tick();
        tick();
        chk("reset wr_valid", 32'(wv0), 32'd0);
        chk("reset wr_addr",  32'(wa0), 32'd0);
        chk("reset wr_data",  32'(wd0), 32'd0);
        chk("reset busy",     32'(bz0), 32'd0);
        chk("reset overflow", 32'(ov0), 32'd0);
        chk("reset frame_done", 32'(fd0), 32'd0);
        reset_n = 1'b1;
        tick();

        // T1: basic frame, ready always high
        clear_logs();
        sendb(8'hA5, 1);
        for (int i = 0; i < 4; i++) send_pix(t1_px[i], 2);
        wait_idle();
        chk("t1 writes i0", 32'(log0.size()), 32'd4);
        chk("t1 writes i1", 32'(log1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk_log("t1", 0, i, 3'(i), t1_px[i]);
            chk_log("t1", 1, i, 3'(i), t1_px[i]);
        end
        chk("t1 frame_done i0", 32'(fdc[0]), 32'd1);
        chk("t1 overflow i0", 32'(ov0), 32'd0);

        // T2: garbage before sync, sync value inside pixel data
        clear_logs();
        sendb(8'h00, 0);
        sendb(8'h11, 1);
        sendb(8'hA5, 0);
        sendb(8'h01, 0);
        sendb(8'hA5, 0);
        sendb(8'h02, 1);
        send_pix(24'h040506, 1);
        send_pix(24'h070809, 1);
        send_pix(24'h0A0B0C, 1);
        wait_idle();
        chk("t2 writes", 32'(log0.size()), 32'd4);
        chk_log("t2", 0, 0, 3'd0, 24'h01A502);
        chk_log("t2", 0, 3, 3'd3, 24'h0A0B0C);

        // T3: full stall, then release; FIFO of 2 drops pixels 2 and 3
        clear_logs();
        wr_ready = 1'b0;
        sendb(8'hA5, 0);
        for (int i = 0; i < 4; i++) send_pix(t3_px[i], 1);
        repeat (5) tick();
        chk("t3 stall wr_valid", 32'(wv0), 32'd1);
        chk("t3 stall wr_addr", 32'(wa0), 32'd0);
        chk("t3 stall wr_data", 32'(wd0), 32'hC0FFEE);
        chk("t3 stall busy", 32'(bz0), 32'd1);
        chk("t3 overflow i0", 32'(ov0), 32'd0);
        chk("t3 overflow i1", 32'(ov1), 32'd1);
        wr_ready = 1'b1;
        wait_idle();
        chk("t3 writes i0", 32'(log0.size()), 32'd4);
        chk("t3 writes i1", 32'(log1.size()), 32'd2);
        for (int i = 0; i < 4; i++) chk_log("t3", 0, i, 3'(i), t3_px[i]);
        chk_log("t3", 1, 0, 3'd0, t3_px[0]);
        chk_log("t3", 1, 1, 3'd1, t3_px[1]);
        chk("t3 frame_done i0", 32'(fdc[0]), 32'd1);
        chk("t3 frame_done i1", 32'(fdc[1]), 32'd1);
        sendb(8'hA5, 0);
        send_pix(24'h010101, 0);
        chk("t3 overflow sticky", 32'(ov1), 32'd1);
        for (int i = 0; i < 3; i++) send_pix(24'h020202, 0);
        wait_idle();

        // T4: FIFO of 2 full, completing byte coincides with the first ready
        pulse_reset();
        clear_logs();
        wr_ready = 1'b0;
        sendb(8'hA5, 0);
        send_pix(24'h111111, 1);
        send_pix(24'h222222, 1);
        sendb(8'h33, 1);
        sendb(8'h33, 1);
        chk("t4 full wr_valid i1", 32'(wv1), 32'd1);
        wr_ready = 1'b1;
        sendb(8'h33, 0);
        wr_ready = 1'b0;
        tick();
        chk("t4 overflow i1", 32'(ov1), 32'd0);
        wr_ready = 1'b1;
        send_pix(24'h444444, 1);
        wait_idle();
        chk("t4 overflow end i1", 32'(ov1), 32'd0);
        chk("t4 writes i1", 32'(log1.size()), 32'd4);
        chk_log("t4", 1, 2, 3'd2, 24'h333333);
        chk_log("t4", 1, 3, 3'd3, 24'h444444);

        // T5: reset with writes pending under a stall
        wr_ready = 1'b0;
        sendb(8'hA5, 0);
        send_pix(24'h515151, 0);
        send_pix(24'h525252, 0);
        send_pix(24'h535353, 0);
        chk("t5 pre overflow i1", 32'(ov1), 32'd1);
        reset_n = 1'b0;
        tick();
        chk("t5 wr_valid", 32'(wv0), 32'd0);
        chk("t5 busy", 32'(bz0), 32'd0);
        chk("t5 overflow i1", 32'(ov1), 32'd0);
        reset_n = 1'b1;
        clear_logs();
        wr_ready = 1'b1;
        sendb(8'hA5, 0);
        send_pix(24'hABCDEF, 1);
        for (int i = 0; i < 3; i++) send_pix(24'h606060 + 24'(i), 1);
        wait_idle();
        chk_log("t5", 0, 0, 3'd0, 24'hABCDEF);
        chk("t5 frame_done", 32'(fdc[0]), 32'd1);

        // T6: random frames, random ready, one mid-frame reset
        rnd_rdy = 1;
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                sendb(b, $urandom_range(0, 2));
            end
            sendb(8'hA5, $urandom_range(0, 2));
            if (f == 3) begin
                for (int i = 0; i < 5; i++) sendb(8'($urandom_range(0, 255)), 0);
                pulse_reset();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    p = 24'($urandom);
                    send_pix(p, 2);
                end
            end
            wait_idle();
        end
        rnd_rdy = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_writer.md
Name: uart_frame_writer

Overview:
- Consumes bytes from the UART receiver FSM (rx_data/rx_done pulse), frames them with a sync byte, and packs BYTES_PER_PIXEL bytes into one pixel word.
- Writes pixels to sequential frame-buffer addresses through a valid/ready write port.
- A small FIFO absorbs frame-buffer stalls.
- Sits between the UART receive path and the VGA frame buffer that the convolution stage reads.

Parameters:
- DBITS, 8, byte width; matches receiver data width
- BYTES_PER_PIXEL, 3, bytes packed per pixel; first received byte lands in the MSBs
- PIXEL_COUNT, 307200, pixels per frame (640x480)
- ADDR_BITS, 19, frame-buffer address width; must satisfy 2**ADDR_BITS >= PIXEL_COUNT
- SYNC_BYTE, 8'hA5, byte that opens a frame
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, >= 2

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous reset, active-low
- rx_data  in  DBITS  received byte; valid only when rx_done=1
- rx_done  in  1  one-cycle strobe, byte available
- wr_addr  out  ADDR_BITS  frame-buffer write address
- wr_data  out  DBITS*BYTES_PER_PIXEL  packed pixel
- wr_valid  out  1  write request
- wr_ready  in  1  frame buffer accepts write when wr_valid&wr_ready
- frame_done  out  1  one-cycle pulse, last pixel of frame accepted by frame buffer
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- busy  out  1  high in COLLECT or DRAIN

Behaviour:
- Reset (reset_n=0 at a rising edge): state=IDLE; byte/pixel counters=0; pack register=0; FIFO emptied; wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, overflow=0, busy=0. Reset mid-frame or mid-stall aborts everything; pending FIFO entries are discarded.
- States:
  - IDLE: rx_done with rx_data==SYNC_BYTE -> COLLECT, byte_cnt=0, pix_cnt=0. Any other byte is ignored.
  - COLLECT: each rx_done shifts rx_data into the pack register, MSB-first (pack = {pack[lower bits], rx_data}), byte_cnt++. SYNC_BYTE value here is ordinary data.
    - On the byte with byte_cnt==BYTES_PER_PIXEL-1: push {pix_cnt, packed word} to the FIFO, byte_cnt=0.
    - If pix_cnt==PIXEL_COUNT-1: -> DRAIN; else pix_cnt++.
  - DRAIN: rx_done ignored. When the FIFO is empty and no write is pending -> IDLE.
- Push timing: completed pixel enters the FIFO on the clock edge following the rx_done cycle. If the FIFO was empty, wr_valid rises that same edge, so the pixel appears one cycle after the completing rx_done.
- Full FIFO: push accepted if not full, or if a pop (wr_valid&wr_ready) occurs in the same cycle. Otherwise the pixel is dropped, overflow sets and stays 1 until reset, and pix_cnt still advances so later pixels keep their correct addresses.
- Write port: wr_valid = FIFO not empty; wr_addr/wr_data = FIFO head. Head is held stable while wr_valid=1 and wr_ready=0. Pop on wr_valid&wr_ready. Back-to-back pops allowed, one per cycle. wr_valid must not depend combinationally on wr_ready.
- frame_done: pulses one cycle after the pop of the entry with addr PIXEL_COUNT-1, coincident with the DRAIN->IDLE transition. If that pixel was dropped, it pulses once the FIFO empties in DRAIN.
- Counter widths: byte_cnt is $clog2(BYTES_PER_PIXEL+1) bits; pix_cnt is ADDR_BITS bits. pix_cnt wraps only by returning to IDLE; no modulo arithmetic.
- busy=1 in COLLECT and DRAIN.

Test Plan:
- Use PIXEL_COUNT=4, BYTES_PER_PIXEL=3, FIFO_DEPTH=4, wr_ready=1. Send A5, 11 22 33, 44 55 66, 77 88 99, AA BB CC -> writes (0,112233), (1,445566), (2,778899), (3,AABBCC); frame_done pulses once; overflow=0.
- Send 00 11 A5 01 02 03 ... in IDLE -> 00 and 11 ignored; first write is (0,010203). A5 sent mid-COLLECT is packed as data: 01 A5 02 -> 01A502.
- Hold wr_ready=0 and send a full 4-pixel frame -> FIFO fills, wr_valid=1 with wr_addr=0/wr_data=first pixel held stable for the whole stall. Release wr_ready -> 4 consecutive writes, then frame_done.
- FIFO_DEPTH=2, wr_ready=0, send 4 pixels -> pixels 2,3 dropped, overflow=1. On release, only addr 0,1 are written; frame_done still pulses; overflow stays 1 into the next frame.
- Full FIFO with the 3rd byte of a pixel arriving in the same cycle as the first wr_ready pulse -> push accepted, no overflow.
- Assert reset_n=0 after 2 pixels, with one write pending under a stall -> next cycle wr_valid=0, busy=0, overflow=0. A new A5-led frame restarts at addr 0.
